// File: rtl/letter_unshifter_stream.sv
// -----------------------------------------------------------------------------
// letter_unshifter_stream
//
// Streaming rotor decryptor: each ciphertext letter c is turned into
// (c - rotor_pos) mod ALPHA_SIZE, and the rotor then advances by STEP.
// Symbols outside the alphabet (char_in >= ALPHA_SIZE) pass through unchanged
// and do not advance the rotor. Two-stage valid/ready pipeline:
//   stage 1 : signed difference char_in - rotor_pos plus a passthrough flag
//   stage 2 : modular wrap, registered char_out
// A key FSM (UNKEYED / RUN / KEY_PEND) gates input acceptance so that a new
// key never takes effect while letters keyed with the old rotor are in flight.
//
// Ports
//   clock      : single clock, rising edge
//   reset      : asynchronous, active-high
//   load_key   : request to load key_value as the new rotor position
//   key_value  : new rotor position (reduced mod ALPHA_SIZE on load)
//   in_valid   : char_in holds a symbol
//   in_ready   : block accepts char_in this cycle
//   char_in    : ciphertext symbol, letters are 0..ALPHA_SIZE-1
//   out_valid  : char_out holds a result
//   out_ready  : downstream accepts char_out this cycle
//   char_out   : plaintext letter or passthrough symbol
//   rotor_pos  : current rotor position
//   busy       : either pipeline stage holds data
// -----------------------------------------------------------------------------
module letter_unshifter_stream #(
    parameter int ALPHA_SIZE = 26,
    parameter int STEP       = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load_key,
    input  logic [7:0] key_value,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] char_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] char_out,
    output logic [7:0] rotor_pos,
    output logic       busy
);

    localparam logic [7:0] ALPHA_W8 = 8'(ALPHA_SIZE);
    localparam logic [8:0] ALPHA_W9 = 9'(ALPHA_SIZE);
    localparam logic [8:0] STEP_W9  = 9'(STEP);

    typedef enum logic [1:0] {
        ST_UNKEYED  = 2'd0,
        ST_RUN      = 2'd1,
        ST_KEY_PEND = 2'd2
    } state_t;

    state_t            state_reg;
    logic [7:0]        rotor_reg;
    logic [7:0]        pend_key_reg;

    logic              s1_valid_reg;
    logic              s1_pass_reg;
    logic signed [8:0] s1_diff_reg;

    logic              s2_valid_reg;
    logic [7:0]        char_out_reg;

    logic              s2_free;
    logic              s1_move;
    logic              accept;
    logic              is_letter;
    logic signed [8:0] letter_diff;
    logic [8:0]        rotor_sum;
    logic [7:0]        rotor_stepped;
    logic [7:0]        wrapped_diff;
    logic [7:0]        s2_result;

    // Stage 2 can take new data when empty or when its word leaves this cycle.
    assign s2_free = !s2_valid_reg || out_ready;
    assign s1_move = s1_valid_reg && s2_free;

    assign busy      = s1_valid_reg || s2_valid_reg;
    // Stage 1 is free exactly when it is empty or moving into stage 2.
    assign in_ready  = (state_reg == ST_RUN) && (!s1_valid_reg || s2_free) && !load_key;
    assign accept    = in_valid && in_ready;
    assign is_letter = (char_in < ALPHA_W8);

    assign out_valid = s2_valid_reg;
    assign char_out  = char_out_reg;
    assign rotor_pos = rotor_reg;

    // Range of the letter difference is -(ALPHA_SIZE-1)..(ALPHA_SIZE-1).
    assign letter_diff = $signed({1'b0, char_in}) - $signed({1'b0, rotor_reg});

    // rotor + STEP never reaches 2*ALPHA_SIZE, so one conditional subtract wraps it.
    assign rotor_sum     = {1'b0, rotor_reg} + STEP_W9;
    assign rotor_stepped = (rotor_sum >= ALPHA_W9) ? 8'(rotor_sum - ALPHA_W9) : rotor_sum[7:0];

    // Negative differences lie in -(ALPHA_SIZE-1)..-1, so adding ALPHA_SIZE in
    // 8-bit arithmetic lands directly in 1..ALPHA_SIZE-1.
    assign wrapped_diff = s1_diff_reg[7:0] + ALPHA_W8;
    assign s2_result    = (!s1_pass_reg && s1_diff_reg[8]) ? wrapped_diff : s1_diff_reg[7:0];

    // Key FSM and rotor.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= ST_UNKEYED;
            rotor_reg    <= 8'd0;
            pend_key_reg <= 8'd0;
        end else begin
            case (state_reg)
                ST_UNKEYED: begin
                    if (load_key) begin
                        rotor_reg <= key_value % ALPHA_W8;
                        state_reg <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (load_key) begin
                        if (busy) begin
                            pend_key_reg <= key_value;
                            state_reg    <= ST_KEY_PEND;
                        end else begin
                            rotor_reg <= key_value % ALPHA_W8;
                        end
                    end else if (accept && is_letter) begin
                        rotor_reg <= rotor_stepped;
                    end
                end
                ST_KEY_PEND: begin
                    if (!busy) begin
                        // A request arriving on the drain edge is the newest key.
                        rotor_reg <= (load_key ? key_value : pend_key_reg) % ALPHA_W8;
                        state_reg <= ST_RUN;
                    end else if (load_key) begin
                        pend_key_reg <= key_value;
                    end
                end
                default: begin
                    state_reg <= ST_UNKEYED;
                end
            endcase
        end
    end

    // Stage 1: unwrapped difference (or raw symbol) plus passthrough flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_reg <= 1'b0;
            s1_pass_reg  <= 1'b0;
            s1_diff_reg  <= '0;
        end else if (accept) begin
            s1_valid_reg <= 1'b1;
            s1_pass_reg  <= !is_letter;
            s1_diff_reg  <= is_letter ? letter_diff : $signed({1'b0, char_in});
        end else if (s1_move) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Stage 2: wrapped result, held stable while downstream stalls.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid_reg <= 1'b0;
            char_out_reg <= 8'd0;
        end else if (s1_move) begin
            s2_valid_reg <= 1'b1;
            char_out_reg <= s2_result;
        end else if (out_ready) begin
            s2_valid_reg <= 1'b0;
        end
    end

endmodule

// File: tb/tb_letter_unshifter_stream.sv
// -----------------------------------------------------------------------------
// tb_letter_unshifter_stream
//
// Scoreboard bench: the stimulus side computes each expected plaintext from a
// simple integer rotor model at the moment a symbol is accepted and queues it;
// a monitor on the falling edge pops and compares every output transfer and
// checks that char_out holds steady during stalls.
// -----------------------------------------------------------------------------
module tb_letter_unshifter_stream;

    localparam int ALPHA = 26;
    localparam int STEP  = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic       load_key;
    logic [7:0] key_value;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] char_in;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] char_out;
    logic [7:0] rotor_pos;
    logic       busy;

    int checks   = 0;
    int failures = 0;
    int exp_q[$];
    int model_rotor = 0;
    bit rand_ready_en = 1'b0;
    bit stalled = 1'b0;
    int held = 0;

    letter_unshifter_stream #(.ALPHA_SIZE(ALPHA), .STEP(STEP)) dut (
        .clock     (clock),
        .reset     (reset),
        .load_key  (load_key),
        .key_value (key_value),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .char_in   (char_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .char_out  (char_out),
        .rotor_pos (rotor_pos),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("ok   %s value=%0d", name, act);
        end
    endtask

    // Monitor: one line per output transfer, stall stability check.
    always @(negedge clock) begin
        if (reset) begin
            stalled = 1'b0;
        end else if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%0d required=none", char_out);
            end else begin
                chk("out_char", int'(char_out), exp_q.pop_front());
            end
            stalled = 1'b0;
        end else if (out_valid) begin
            if (stalled) chk("stall_stable", int'(char_out), held);
            held    = int'(char_out);
            stalled = 1'b1;
        end else begin
            stalled = 1'b0;
        end
    end

    // Random backpressure.
    always @(posedge clock) begin
        if (rand_ready_en) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Offer one symbol until accepted; the expectation is queued on acceptance.
    task automatic send(input int c);
        int tries = 0;
        bit done  = 1'b0;
        while (!done) begin
            @(posedge clock); #1;
            in_valid = 1'b1;
            char_in  = 8'(c);
            @(negedge clock);
            if (in_ready) begin
                if (c < ALPHA) begin
                    exp_q.push_back((c - model_rotor + ALPHA) % ALPHA);
                    model_rotor = (model_rotor + STEP) % ALPHA;
                end else begin
                    exp_q.push_back(c);
                end
                done = 1'b1;
            end else if (++tries > 200) begin
                chk("send_timeout", 0, 1);
                done = 1'b1;
            end
        end
    endtask

    task automatic finish_send();
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    task automatic load(input int k);
        @(posedge clock); #1;
        load_key  = 1'b1;
        key_value = 8'(k);
        @(posedge clock); #1;
        load_key  = 1'b0;
        model_rotor = k % ALPHA;
    endtask

    // Key request with a competing valid symbol: the symbol must be refused.
    task automatic reload(input int k);
        @(posedge clock); #1;
        load_key  = 1'b1;
        key_value = 8'(k);
        in_valid  = 1'b1;
        char_in   = 8'($urandom_range(0, 255));
        @(negedge clock);
        chk("load_blocks_in", int'(in_ready), 0);
        @(posedge clock); #1;
        load_key = 1'b0;
        in_valid = 1'b0;
        model_rotor = k % ALPHA;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 500) begin
            @(negedge clock);
            n++;
        end
        chk("drained", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        load_key  = 1'b0;
        key_value = 8'd0;
        in_valid  = 1'b0;
        char_in   = 8'd0;
        out_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready",  int'(in_ready), 0);
        chk("rst_busy",      int'(busy), 0);
        chk("rst_rotor",     int'(rotor_pos), 0);
        chk("rst_char_out",  int'(char_out), 0);

        // Unkeyed block refuses input.
        @(posedge clock); #1;
        reset    = 1'b0;
        in_valid = 1'b1;
        char_in  = 8'd4;
        @(negedge clock);
        chk("unkeyed_in_ready", int'(in_ready), 0);
        @(posedge clock); #1;
        in_valid = 1'b0;

        // Key 3, letter B -> Y, two edges from presentation to output.
        load(3);
        chk("key3_rotor", int'(rotor_pos), 3);
        @(posedge clock); #1;
        in_valid = 1'b1;
        char_in  = 8'd1;
        @(negedge clock);
        chk("first_in_ready", int'(in_ready), 1);
        exp_q.push_back((1 - model_rotor + ALPHA) % ALPHA);
        model_rotor = (model_rotor + STEP) % ALPHA;
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("lat_edge1_valid", int'(out_valid), 0);
        @(posedge clock); #1;
        chk("lat_edge2_valid", int'(out_valid), 1);
        chk("lat_char_y", int'(char_out), 24);
        chk("rotor_after_b", int'(rotor_pos), 4);
        drain();

        // Key 25, two A's back to back: rotor wraps 25 -> 0 -> 1.
        load(25);
        send(0);
        send(0);
        finish_send();
        drain();
        chk("wrap_rotor", int'(rotor_pos), 1);

        // Non-letter passes through without stepping the rotor.
        load(2);
        send(40);
        send(2);
        finish_send();
        drain();
        chk("pass_rotor", int'(rotor_pos), 3);

        // Full rotor revolution with a 3-cycle downstream stall mid-stream.
        load(0);
        fork
            begin
                for (int i = 0; i < 26; i++) send(5);
                finish_send();
            end
            begin
                repeat (10) @(posedge clock);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clock);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("rev_rotor", int'(rotor_pos), 0);

        // Key request while busy: pending until drained, old rotor for in-flight data.
        load(2);
        out_ready = 1'b0;
        send(10);
        send(11);
        finish_send();
        @(posedge clock); #1;
        load_key  = 1'b1;
        key_value = 8'd7;
        @(negedge clock);
        chk("busy_at_load", int'(busy), 1);
        chk("load_in_ready", int'(in_ready), 0);
        @(posedge clock); #1;
        load_key  = 1'b0;
        @(negedge clock);
        chk("pend_in_ready", int'(in_ready), 0);
        chk("pend_rotor_old", int'(rotor_pos), 4);
        @(posedge clock); #1;
        out_ready = 1'b1;
        begin
            int n = 0;
            @(negedge clock);
            while (busy && n < 50) begin
                @(negedge clock);
                n++;
            end
            chk("pend_drain", int'(busy), 0);
        end
        chk("pend_in_ready_idle", int'(in_ready), 0);
        @(posedge clock); #1;
        chk("pend_rotor_new", int'(rotor_pos), 7);
        chk("run_in_ready", int'(in_ready), 1);
        model_rotor = 7;
        drain();

        // Reset with two letters in flight.
        load(1);
        out_ready = 1'b0;
        send(3);
        send(4);
        finish_send();
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_in_ready", int'(in_ready), 0);
        chk("midrst_rotor", int'(rotor_pos), 0);
        chk("midrst_char_out", int'(char_out), 0);
        exp_q.delete();
        model_rotor = 0;
        out_ready   = 1'b1;
        @(posedge clock); #1;
        reset     = 1'b0;
        load_key  = 1'b1;
        key_value = 8'd5;
        @(posedge clock); #1;
        load_key  = 1'b0;
        chk("post_rst_key", int'(rotor_pos), 5);
        model_rotor = 5;
        send(6);
        finish_send();
        drain();

        // Randomized traffic with backpressure and occasional rekeying.
        load($urandom_range(0, 255));
        rand_ready_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0) reload($urandom_range(0, 255));
            else if (r < 4) send($urandom_range(26, 255));
            else send($urandom_range(0, 25));
        end
        finish_send();
        rand_ready_en = 1'b0;
        @(posedge clock); #1;
        out_ready = 1'b1;
        drain();
        chk("rand_rotor", int'(rotor_pos), model_rotor);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
